// File: rtl/conv_sched_pkg.sv
// Shared constants and helpers for the Conv engine control sequencer.
// State encodings, kernel/pad constants and the filter index calculation.
package conv_sched_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LD_FILT = 3'd1;
    localparam logic [2:0] ST_LD_IMG  = 3'd2;
    localparam logic [2:0] ST_CONV    = 3'd3;
    localparam logic [2:0] ST_FIN     = 3'd4;

    localparam logic [2:0] K3 = 3'd3;
    localparam logic [2:0] K5 = 3'd5;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;

    localparam int CS_MIN_N = 3;
    localparam int CS_MAX_N = 8;

    function automatic logic [2:0] k_of(input logic fs);
        return fs ? K5 : K3;
    endfunction

    function automatic logic [1:0] p_of(input logic fs);
        return fs ? P2 : P1;
    endfunction

    // Raster index ky*K+kx; with ky=kx=K-1 this also gives the last filter address.
    function automatic logic [4:0] tap_index(input logic fs, input logic [2:0] ky, input logic [2:0] kx);
        return ({2'b00, ky} * {2'b00, k_of(fs)}) + {2'b00, kx};
    endfunction

endpackage

// File: rtl/conv_sched_if.sv
// Port bundle between the job source / buffers / MAC array and the Conv sequencer.
interface conv_sched_if;

    logic       filter_valid;
    logic       image_valid;
    logic       filter_size;
    logic [3:0] image_size;
    logic       pad_mode;
    logic       act_mode;
    logic       stall;

    logic       filt_we;
    logic [4:0] filt_addr;
    logic       img_we;
    logic [2:0] img_wr_row;
    logic [2:0] img_wr_col;
    logic       tap_valid;
    logic [2:0] tap_row;
    logic [2:0] tap_col;
    logic [4:0] tap_idx;
    logic       tap_zero;
    logic       acc_clr;
    logic       acc_last;
    logic       cfg_k5;
    logic       cfg_act;
    logic       busy;
    logic       done;

    modport master (
        output filter_valid, image_valid, filter_size, image_size, pad_mode, act_mode, stall,
        input  filt_we, filt_addr, img_we, img_wr_row, img_wr_col,
        input  tap_valid, tap_row, tap_col, tap_idx, tap_zero, acc_clr, acc_last,
        input  cfg_k5, cfg_act, busy, done
    );

    modport slave (
        input  filter_valid, image_valid, filter_size, image_size, pad_mode, act_mode, stall,
        output filt_we, filt_addr, img_we, img_wr_row, img_wr_col,
        output tap_valid, tap_row, tap_col, tap_idx, tap_zero, acc_clr, acc_last,
        output cfg_k5, cfg_act, busy, done
    );

endinterface

// File: rtl/conv_sched_tap_addr.sv
// Maps an output pixel plus kernel offset to a padded source coordinate.
// Out-of-range axes either clamp to the nearest edge or flag the tap as zero.
module conv_tap_addr
    import conv_sched_pkg::*;
(
    input  logic [2:0] i_row,
    input  logic [2:0] i_col,
    input  logic [2:0] i_ky,
    input  logic [2:0] i_kx,
    input  logic [3:0] i_n,
    input  logic [1:0] i_pad_amt,
    input  logic       i_pad_mode,
    output logic [2:0] o_tap_row,
    output logic [2:0] o_tap_col,
    output logic       o_tap_zero
);

    logic [3:0] w_row_ax;
    logic [3:0] w_col_ax;

    // Returns {out_of_range, clamped coordinate} for one axis.
    function automatic logic [3:0] clamp_axis(input logic [2:0] base, input logic [2:0] k,
                                              input logic [1:0] p, input logic [3:0] n);
        logic signed [4:0] s;
        logic [3:0]        nm1;
        s   = $signed({2'b00, base}) + $signed({2'b00, k}) - $signed({3'b000, p});
        nm1 = n - 4'd1;
        if (s < 5'sd0) begin
            return {1'b1, 3'd0};
        end else if (s > $signed({1'b0, nm1})) begin
            return {1'b1, nm1[2:0]};
        end else begin
            return {1'b0, s[2:0]};
        end
    endfunction

    assign w_row_ax = clamp_axis(i_row, i_ky, i_pad_amt, i_n);
    assign w_col_ax = clamp_axis(i_col, i_kx, i_pad_amt, i_n);

    always_comb begin
        o_tap_zero = !i_pad_mode && (w_row_ax[3] || w_col_ax[3]);
        o_tap_row  = o_tap_zero ? 3'd0 : w_row_ax[2:0];
        o_tap_col  = o_tap_zero ? 3'd0 : w_col_ax[2:0];
    end

endmodule

// File: rtl/conv_sched.sv
// Conv engine sequencer: latches job config, steers buffer write addresses while loading,
// then walks output pixels and kernel taps in raster order issuing MAC strobes.
module conv_sched
    import conv_sched_pkg::*;
#(
    parameter int MAX_N = CS_MAX_N,
    parameter int MIN_N = CS_MIN_N
) (
    input  logic          clk,
    input  logic          rst,
    conv_sched_if.slave   io_bus
);

    localparam logic [3:0] LP_MAX_N = 4'(MAX_N);
    localparam logic [3:0] LP_MIN_N = 4'(MIN_N);

    logic [2:0] r_state;
    logic [4:0] r_fcnt;
    logic [2:0] r_wr_row, r_wr_col;
    logic       r_k5, r_pad, r_act;
    logic [3:0] r_n;
    logic [2:0] r_r, r_c, r_ky, r_kx;

    logic       r_filt_we, r_img_we, r_tap_valid, r_tap_zero, r_acc_clr, r_acc_last, r_busy, r_done;
    logic [4:0] r_filt_addr, r_tap_idx;
    logic [2:0] r_img_wr_row, r_img_wr_col, r_tap_row, r_tap_col;

    logic [3:0] w_n_in, w_n_m1_full;
    logic [2:0] w_n_m1, w_k_m1;
    logic [4:0] w_kk_m1;
    logic [1:0] w_p;
    logic       w_kx_end, w_ky_end, w_c_end, w_r_end, w_img_col_end, w_img_row_end;
    logic [2:0] w_tap_row, w_tap_col;
    logic       w_tap_zero;

    assign w_n_in        = (io_bus.image_size < LP_MIN_N) ? LP_MIN_N :
                           (io_bus.image_size > LP_MAX_N) ? LP_MAX_N : io_bus.image_size;
    assign w_n_m1_full   = r_n - 4'd1;
    assign w_n_m1        = w_n_m1_full[2:0];
    assign w_k_m1        = k_of(r_k5) - 3'd1;
    assign w_kk_m1       = tap_index(r_k5, w_k_m1, w_k_m1);
    assign w_p           = p_of(r_k5);
    assign w_kx_end      = (r_kx == w_k_m1);
    assign w_ky_end      = (r_ky == w_k_m1);
    assign w_c_end       = (r_c == w_n_m1);
    assign w_r_end       = (r_r == w_n_m1);
    assign w_img_col_end = (r_wr_col == w_n_m1);
    assign w_img_row_end = (r_wr_row == w_n_m1);

    conv_tap_addr u_tap_addr (
        .i_row      (r_r),
        .i_col      (r_c),
        .i_ky       (r_ky),
        .i_kx       (r_kx),
        .i_n        (r_n),
        .i_pad_amt  (w_p),
        .i_pad_mode (r_pad),
        .o_tap_row  (w_tap_row),
        .o_tap_col  (w_tap_col),
        .o_tap_zero (w_tap_zero)
    );

    // Strobes default low every cycle; busy is registered alongside them so it lines up with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_fcnt <= '0; r_wr_row <= '0; r_wr_col <= '0;
            r_k5 <= 1'b0; r_pad <= 1'b0; r_act <= 1'b0; r_n <= '0;
            r_r <= '0; r_c <= '0; r_ky <= '0; r_kx <= '0;
            r_filt_we <= 1'b0; r_filt_addr <= '0;
            r_img_we <= 1'b0; r_img_wr_row <= '0; r_img_wr_col <= '0;
            r_tap_valid <= 1'b0; r_tap_row <= '0; r_tap_col <= '0; r_tap_idx <= '0; r_tap_zero <= 1'b0;
            r_acc_clr <= 1'b0; r_acc_last <= 1'b0;
            r_busy <= 1'b0; r_done <= 1'b0;
        end else begin
            r_filt_we   <= 1'b0;
            r_img_we    <= 1'b0;
            r_tap_valid <= 1'b0;
            r_acc_clr   <= 1'b0;
            r_acc_last  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_busy <= io_bus.filter_valid;
                    if (io_bus.filter_valid) begin
                        r_k5        <= io_bus.filter_size;
                        r_n         <= w_n_in;
                        r_pad       <= io_bus.pad_mode;
                        r_act       <= io_bus.act_mode;
                        r_filt_we   <= 1'b1;
                        r_filt_addr <= 5'd0;
                        r_fcnt      <= 5'd1;
                        r_wr_row    <= 3'd0;
                        r_wr_col    <= 3'd0;
                        r_state     <= ST_LD_FILT;
                    end
                end
                ST_LD_FILT: begin
                    if (io_bus.filter_valid) begin
                        r_filt_we   <= 1'b1;
                        r_filt_addr <= r_fcnt;
                        r_fcnt      <= r_fcnt + 5'd1;
                        if (r_fcnt == w_kk_m1) begin
                            r_state <= ST_LD_IMG;
                        end
                    end
                end
                ST_LD_IMG: begin
                    if (io_bus.image_valid) begin
                        r_img_we     <= 1'b1;
                        r_img_wr_row <= r_wr_row;
                        r_img_wr_col <= r_wr_col;
                        if (w_img_col_end) begin
                            r_wr_col <= 3'd0;
                            r_wr_row <= r_wr_row + 3'd1;
                            if (w_img_row_end) begin
                                r_r <= '0; r_c <= '0; r_ky <= '0; r_kx <= '0;
                                r_state <= ST_CONV;
                            end
                        end else begin
                            r_wr_col <= r_wr_col + 3'd1;
                        end
                    end
                end
                ST_CONV: begin
                    if (!io_bus.stall) begin
                        r_tap_valid <= 1'b1;
                        r_tap_row   <= w_tap_row;
                        r_tap_col   <= w_tap_col;
                        r_tap_zero  <= w_tap_zero;
                        r_tap_idx   <= tap_index(r_k5, r_ky, r_kx);
                        r_acc_clr   <= (r_ky == 3'd0) && (r_kx == 3'd0);
                        r_acc_last  <= w_ky_end && w_kx_end;
                        if (!w_kx_end) begin
                            r_kx <= r_kx + 3'd1;
                        end else begin
                            r_kx <= 3'd0;
                            if (!w_ky_end) begin
                                r_ky <= r_ky + 3'd1;
                            end else begin
                                r_ky <= 3'd0;
                                if (!w_c_end) begin
                                    r_c <= r_c + 3'd1;
                                end else begin
                                    r_c <= 3'd0;
                                    if (!w_r_end) begin
                                        r_r <= r_r + 3'd1;
                                    end else begin
                                        r_r     <= 3'd0;
                                        r_state <= ST_FIN;
                                    end
                                end
                            end
                        end
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_bus.filt_we    = r_filt_we;
    assign io_bus.filt_addr  = r_filt_addr;
    assign io_bus.img_we     = r_img_we;
    assign io_bus.img_wr_row = r_img_wr_row;
    assign io_bus.img_wr_col = r_img_wr_col;
    assign io_bus.tap_valid  = r_tap_valid;
    assign io_bus.tap_row    = r_tap_row;
    assign io_bus.tap_col    = r_tap_col;
    assign io_bus.tap_idx    = r_tap_idx;
    assign io_bus.tap_zero   = r_tap_zero;
    assign io_bus.acc_clr    = r_acc_clr;
    assign io_bus.acc_last   = r_acc_last;
    assign io_bus.cfg_k5     = r_k5;
    assign io_bus.cfg_act    = r_act;
    assign io_bus.busy       = r_busy;
    assign io_bus.done       = r_done;

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched: expected writes and taps are queued when a job is driven
// and checked in order as the sequencer emits them.
module tb_conv_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_sched_if bus();

    conv_sched dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int testsRun = 0;
    int testsFailed = 0;

    logic [13:0] tapQ[$];
    logic [4:0]  filtQ[$];
    logic [5:0]  imgQ[$];

    int tapCnt, filtCnt, imgCnt, clrCnt, lastCnt, doneCnt, cyc, lastAccCyc, doneCyc;
    logic [8:0]  zeroVec;
    logic [13:0] lastTap;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] allOuts();
        return {bus.filt_we, bus.filt_addr, bus.img_we, bus.img_wr_row, bus.img_wr_col,
                bus.tap_valid, bus.tap_row, bus.tap_col, bus.tap_idx, bus.tap_zero,
                bus.acc_clr, bus.acc_last, bus.cfg_k5, bus.cfg_act, bus.busy, bus.done};
    endfunction

    // Output monitor: pops the scoreboard on every strobe, sampled on the falling edge.
    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (bus.filt_we) begin
                    filtCnt++;
                    if (filtQ.size() == 0) checkOutput("filt_unexpected", 32'(bus.filt_addr), 32'hFFFF);
                    else checkOutput("filt_addr", 32'(bus.filt_addr), 32'(filtQ.pop_front()));
                end
                if (bus.img_we) begin
                    imgCnt++;
                    if (imgQ.size() == 0) checkOutput("img_unexpected", 32'({bus.img_wr_row, bus.img_wr_col}), 32'hFFFF);
                    else checkOutput("img_addr", 32'({bus.img_wr_row, bus.img_wr_col}), 32'(imgQ.pop_front()));
                end
                if (bus.tap_valid) begin
                    lastTap = {bus.tap_row, bus.tap_col, bus.tap_idx, bus.tap_zero, bus.acc_clr, bus.acc_last};
                    if (tapQ.size() == 0) checkOutput("tap_unexpected", 32'(lastTap), 32'hFFFF);
                    else checkOutput("tap", 32'(lastTap), 32'(tapQ.pop_front()));
                    if (tapCnt < 9) zeroVec[tapCnt] = bus.tap_zero;
                    tapCnt++;
                    if (bus.acc_clr) clrCnt++;
                    if (bus.acc_last) begin
                        lastCnt++;
                        lastAccCyc = cyc;
                    end
                end
                if (bus.done) begin
                    doneCnt++;
                    doneCyc = cyc;
                end
            end
        end
    end

    task automatic applyStimulus(input bit k5, input logic [3:0] isz, input bit pad, input bit act,
                                 input bit gaps, input int stallAt, input int abortAt);
        int K, P, N, sr, sc, er, ec;
        bit ez, stalled, aborted;
        K = k5 ? 5 : 3;
        P = k5 ? 2 : 1;
        N = (isz < 3) ? 3 : ((isz > 8) ? 8 : int'(isz));
        tapCnt = 0; filtCnt = 0; imgCnt = 0; clrCnt = 0; lastCnt = 0; doneCnt = 0;
        zeroVec = '0; lastAccCyc = 0; doneCyc = 0;
        tapQ.delete(); filtQ.delete(); imgQ.delete();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++) begin
                        sr = r + ky - P;
                        sc = c + kx - P;
                        ez = 1'b0;
                        er = sr;
                        ec = sc;
                        if (sr < 0 || sr >= N || sc < 0 || sc >= N) begin
                            if (pad) begin
                                if (sr < 0) er = 0; else if (sr >= N) er = N - 1;
                                if (sc < 0) ec = 0; else if (sc >= N) ec = N - 1;
                            end else begin
                                ez = 1'b1; er = 0; ec = 0;
                            end
                        end
                        tapQ.push_back({3'(er), 3'(ec), 5'(ky * K + kx), ez,
                                        (ky == 0 && kx == 0), (ky == K - 1 && kx == K - 1)});
                    end
        for (int i = 0; i < K * K; i++) begin
            bus.filter_valid = 1'b1;
            bus.filter_size  = (i == 0) ? k5 : ~k5;
            bus.image_size   = (i == 0) ? isz : ~isz;
            bus.pad_mode     = (i == 0) ? pad : ~pad;
            bus.act_mode     = (i == 0) ? act : ~act;
            filtQ.push_back(5'(i));
            @(posedge clk); #1;
            bus.filter_valid = 1'b0;
            if (gaps && (i % 3 == 1)) begin
                bus.image_valid = 1'b1;
                @(posedge clk); #1;
                bus.image_valid = 1'b0;
            end
        end
        if (gaps) begin
            bus.filter_valid = 1'b1;
            @(posedge clk); #1;
            bus.filter_valid = 1'b0;
        end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                bus.image_valid = 1'b1;
                imgQ.push_back({3'(r), 3'(c)});
                @(posedge clk); #1;
                bus.image_valid = 1'b0;
                if (gaps && c == 1) begin
                    bus.filter_valid = 1'b1;
                    @(posedge clk); #1;
                    bus.filter_valid = 1'b0;
                end
            end
        stalled = 1'b0;
        aborted = 1'b0;
        for (int t = 0; t < 5000 && doneCnt == 0 && !aborted; t++) begin
            if (abortAt >= 0 && tapCnt >= abortAt) begin
                rst = 1'b1;
                @(posedge clk); #1;
                checkOutput("abort_outs", allOuts(), 32'h0);
                rst = 1'b0;
                tapQ.delete(); filtQ.delete(); imgQ.delete();
                repeat (5) begin @(posedge clk); #1; end
                checkOutput("abort_no_done", 32'(doneCnt), 32'd0);
                checkOutput("abort_busy", 32'(bus.busy), 32'd0);
                aborted = 1'b1;
            end else begin
                if (stallAt >= 0 && !stalled && tapCnt >= stallAt) begin
                    bus.stall = 1'b1;
                    repeat (5) begin
                        @(posedge clk); #1;
                        checkOutput("stall_tap_valid", 32'(bus.tap_valid), 32'd0);
                    end
                    bus.stall = 1'b0;
                    stalled = 1'b1;
                end
                @(posedge clk); #1;
            end
        end
        if (!aborted) begin
            if (doneCnt == 0) checkOutput("done_timeout", 32'd0, 32'd1);
            repeat (3) begin @(posedge clk); #1; end
            checkOutput("filt_count", 32'(filtCnt), 32'(K * K));
            checkOutput("img_count", 32'(imgCnt), 32'(N * N));
            checkOutput("tap_count", 32'(tapCnt), 32'(N * N * K * K));
            checkOutput("clr_count", 32'(clrCnt), 32'(N * N));
            checkOutput("last_count", 32'(lastCnt), 32'(N * N));
            checkOutput("done_count", 32'(doneCnt), 32'd1);
            checkOutput("done_latency", 32'(doneCyc - lastAccCyc), 32'd1);
            checkOutput("tapq_empty", 32'(tapQ.size()), 32'd0);
            checkOutput("cfg", 32'({bus.cfg_k5, bus.cfg_act}), 32'({k5, act}));
            checkOutput("idle_busy", 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.filter_valid = 1'b0; bus.image_valid = 1'b0; bus.filter_size = 1'b0;
        bus.image_size = 4'd0; bus.pad_mode = 1'b0; bus.act_mode = 1'b0; bus.stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outs", allOuts(), 32'h0);
        rst = 1'b0;
        bus.image_valid = 1'b1;
        @(posedge clk); #1;
        bus.image_valid = 1'b0;
        checkOutput("idle_img_ignored", 32'({bus.img_we, bus.busy}), 32'd0);

        $display("[TB] T1: K=3 N=3 zero pad");
        applyStimulus(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, -1, -1);

        $display("[TB] T2: K=3 N=4 zero pad with gaps");
        applyStimulus(1'b0, 4'd4, 1'b0, 1'b1, 1'b1, -1, -1);
        checkOutput("t2_zero_pattern", 32'(zeroVec), 32'h04F);

        $display("[TB] T3: K=5 N=4 replicate");
        applyStimulus(1'b1, 4'd4, 1'b1, 1'b0, 1'b0, -1, -1);
        checkOutput("t3_taps", 32'(tapCnt), 32'd400);
        checkOutput("t3_last_tap", 32'(lastTap), 32'({3'd3, 3'd3, 5'd24, 1'b0, 1'b0, 1'b1}));

        $display("[TB] T4: stall mid-pixel");
        applyStimulus(1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 4, -1);

        $display("[TB] T5: image_size clamping");
        applyStimulus(1'b0, 4'd10, 1'b0, 1'b0, 1'b0, -1, -1);
        checkOutput("t5_img_n8", 32'(imgCnt), 32'd64);
        applyStimulus(1'b0, 4'd1, 1'b1, 1'b0, 1'b1, -1, -1);
        checkOutput("t5_img_n3", 32'(imgCnt), 32'd9);

        $display("[TB] T6: reset during CONV then fresh job");
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b1, 1'b0, -1, 30);
        applyStimulus(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
